// File: rtl/sync_fifo_rd_ctrl_pkg.sv
// Shared FIFO sizing macros and read-side controller types.
// The sizing macros are shared with the write-side controller, so they are
// guarded and defined before the package that uses them.
`ifndef SYNC_FIFO_DEFINES_VH
`define SYNC_FIFO_DEFINES_VH
`define FIFO_DEPTH 8
`define DATA_WIDTH 8
`define PTR_WIDTH ($clog2(`FIFO_DEPTH)+1)
`endif

package sync_fifo_rd_ctrl_pkg;

   // Output stage state; OS_FULL means the output register holds a valid word.
   typedef enum logic {
      OS_IDLE = 1'b0,
      OS_FULL = 1'b1
   } out_state_t;

   localparam int DEF_MEM_DEPTH  = `FIFO_DEPTH;
   localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
   localparam int DEF_PTR_WIDTH  = `PTR_WIDTH;

endpackage

// File: rtl/sync_fifo_out_stage.sv
// Registered show-ahead output stage: data/valid register and fetch decision.
//
// Handshake: a word transfers on a rising edge where m_valid && m_ready.
// While m_valid && !m_ready, m_data and m_valid hold stable. m_valid never
// depends combinationally on m_ready.
module sync_fifo_out_stage
   import sync_fifo_rd_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_empty,
   input  logic                  m_ready,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  fetch,
   output logic                  valid_nxt,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output out_state_t            state_dbg
);

   out_state_t state_q;
   out_state_t state_d;

   // State register: the output-valid flag.
   always_ff @(posedge clk) begin
      if (reset) state_q <= OS_IDLE;
      else       state_q <= state_d;
   end

   // Next state: flush empties the stage; otherwise refill whenever storage has data.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = OS_IDLE;
      end else begin
         case (state_q)
            OS_IDLE: if (!mem_empty)            state_d = OS_FULL;
            OS_FULL: if (m_ready && mem_empty)  state_d = OS_IDLE;
            default:                            state_d = OS_IDLE;
         endcase
      end
   end

   // Outputs: a fetch happens only when the register is free or being drained, never on flush.
   always_comb begin
      m_valid   = (state_q == OS_FULL);
      fetch     = !flush && !mem_empty && (!m_valid || m_ready);
      valid_nxt = (state_d == OS_FULL);
      state_dbg = state_q;
   end

   // Data register: loads only on a fetch, so it keeps its old value when drained.
   always_ff @(posedge clk) begin
      if (reset)      m_data <= '0;
      else if (fetch) m_data <= rd_data;
   end

endmodule

// File: rtl/sync_fifo_rd_ctrl.sv
// Read-side controller of the synchronous FIFO: read pointer, storage read
// address, occupancy level and the registered show-ahead output stage.
module sync_fifo_rd_ctrl
   import sync_fifo_rd_ctrl_pkg::*;
#(
   parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int PTR_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PTR_WIDTH-1:0]  wr_ptr,
   output logic [PTR_WIDTH-1:0]  rd_ptr,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  empty,
   output logic [PTR_WIDTH:0]    level
);

   logic [PTR_WIDTH-1:0] rd_ptr_q;
   logic [PTR_WIDTH-1:0] rd_ptr_d;
   logic [PTR_WIDTH-1:0] mem_cnt_nxt;
   logic [PTR_WIDTH:0]   level_q;
   logic [PTR_WIDTH:0]   level_d;
   logic                 mem_empty;
   logic                 fetch;
   logic                 valid_nxt;
   out_state_t           os_state;

   sync_fifo_out_stage #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_stage (
      .clk       (clk),
      .reset     (reset),
      .mem_empty (mem_empty),
      .m_ready   (m_ready),
      .flush     (flush),
      .rd_data   (rd_data),
      .fetch     (fetch),
      .valid_nxt (valid_nxt),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .state_dbg (os_state)
   );

   // Storage addressing and emptiness follow the current read pointer.
   always_comb begin
      rd_addr   = rd_ptr_q[ADDR_WIDTH-1:0];
      mem_empty = (rd_ptr_q == wr_ptr);
      rd_ptr    = rd_ptr_q;
      level     = level_q;
      empty     = (os_state == OS_IDLE);
   end

   // Next pointer and level: flush snaps to the write pointer, a fetch advances by one.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      if (flush)      rd_ptr_d = wr_ptr;
      else if (fetch) rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      mem_cnt_nxt = wr_ptr - rd_ptr_d;
      level_d     = {1'b0, mem_cnt_nxt} + {{PTR_WIDTH{1'b0}}, valid_nxt};
   end

   // Pointer and level registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: tb/tb_sync_fifo_rd_ctrl.sv
// Directed bench for sync_fifo_rd_ctrl with a simple write-side model and
// storage array around it.
module tb_sync_fifo_rd_ctrl;

   localparam int MEM_DEPTH  = 8;
   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 3;
   localparam int PTR_WIDTH  = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [PTR_WIDTH-1:0]  wr_ptr;
   logic [PTR_WIDTH-1:0]  rd_ptr;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  flush;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_valid;
   logic                  m_ready;
   logic                  empty;
   logic [PTR_WIDTH:0]    level;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic                  wr_en;
   logic                  wr_jump;
   logic [PTR_WIDTH-1:0]  wr_jump_val;

   int checks = 0;
   int errors = 0;

   // clock / reset
   always #5 clk = ~clk;

   // write-side model: storage is filled by the stimulus before wr_ptr advances
   always @(posedge clk) begin
      if (reset)        wr_ptr <= '0;
      else if (wr_jump) wr_ptr <= wr_jump_val;
      else if (wr_en)   wr_ptr <= wr_ptr + 4'd1;
   end

   assign rd_data = mem[rd_addr];

   sync_fifo_rd_ctrl #(
      .MEM_DEPTH  (MEM_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_ptr  (wr_ptr),
      .rd_ptr  (rd_ptr),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .flush   (flush),
      .m_data  (m_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .empty   (empty),
      .level   (level)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   int                    sent;
   int                    next_exp;
   int                    cyc;
   bit                    stalled;
   bit                    saw_wrap;
   logic [DATA_WIDTH-1:0] held;
   logic [ADDR_WIDTH-1:0] prev_addr;
   logic [ADDR_WIDTH-1:0] nxt_addr;
   logic [PTR_WIDTH-1:0]  cnt;
   bit                    pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      reset = 1'b1; flush = 1'b0; m_ready = 1'b0;
      wr_en = 1'b0; wr_jump = 1'b0; wr_jump_val = '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
      repeat (2) @(negedge clk);

      // reset values while reset is held
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_rd_ptr", rd_ptr, 0);
      reset = 1'b0;

      // idle with wr_ptr held at zero
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_valid", m_valid, 0);
         chk("idle_empty", empty, 1);
         chk("idle_level", level, 0);
         chk("idle_rd_ptr", rd_ptr, 0);
      end

      // single word: wr_ptr advances at edge N, m_valid after edge N+1
      mem[0] = 8'hA5; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      chk("single_n_valid", m_valid, 0);
      @(negedge clk);
      chk("single_valid", m_valid, 1);
      chk("single_data", m_data, 8'hA5);
      chk("single_level", level, 1);
      chk("single_rd_ptr", rd_ptr, 1);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      chk("single_drain_valid", m_valid, 0);
      chk("single_drain_rd_ptr", rd_ptr, 1);
      chk("single_drain_level", level, 0);
      chk("single_drain_empty", empty, 1);
      chk("single_drain_data", m_data, 8'hA5);

      // streaming: 8 preloaded words, m_ready held high
      do_reset();
      for (int i = 0; i < 8; i++) mem[i] = 8'(i);
      wr_jump = 1'b1; wr_jump_val = 4'd8; m_ready = 1'b1;
      @(negedge clk);
      wr_jump = 1'b0;
      chk("stream_pre_valid", m_valid, 0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("stream_valid", m_valid, 1);
         chk("stream_data", m_data, k);
         chk("stream_level", level, 8 - k);
      end
      chk("stream_rd_ptr", rd_ptr, 8);
      @(negedge clk);
      m_ready = 1'b0;
      chk("stream_end_valid", m_valid, 0);
      chk("stream_end_level", level, 0);
      chk("stream_end_rd_ptr", rd_ptr, 8);

      // wrap and backpressure: 20 words, m_ready pattern 1-0-0-1
      do_reset();
      sent = 0; next_exp = 0; cyc = 0; stalled = 1'b0; saw_wrap = 1'b0;
      prev_addr = '0; held = '0;
      while (next_exp < 20 && cyc < 400) begin
         cnt = wr_ptr - rd_ptr;
         chk("ptr_sanity", (cnt <= 4'd8), 1);
         if (stalled) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, held);
         end
         if (rd_addr != prev_addr) begin
            nxt_addr = prev_addr + 3'd1;
            chk("addr_step", rd_addr, nxt_addr);
            if (prev_addr == 3'd7) saw_wrap = 1'b1;
            prev_addr = rd_addr;
         end
         m_ready = pat[cyc % 4];
         if (m_valid && m_ready) begin
            chk("wrap_data", m_data, next_exp);
            next_exp++;
         end
         stalled = m_valid && !m_ready;
         held = m_data;
         if (sent < 20 && cnt < 4'd8) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] = 8'(sent);
            wr_en = 1'b1;
            sent++;
         end else begin
            wr_en = 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      wr_en = 1'b0; m_ready = 1'b0;
      chk("wrap_timeout", (cyc < 400), 1);
      chk("wrap_count", next_exp, 20);
      chk("wrap_seen", saw_wrap, 1);
      chk("wrap_rd_ptr", rd_ptr, 4);
      chk("wrap_end_valid", m_valid, 0);

      // flush with accept and a same-cycle write
      do_reset();
      for (int i = 0; i < 6; i++) mem[i] = 8'(8'h10 + i);
      wr_jump = 1'b1; wr_jump_val = 4'd6;
      @(negedge clk);
      wr_jump = 1'b0;
      @(negedge clk);
      chk("flush_pre_valid", m_valid, 1);
      chk("flush_pre_data", m_data, 8'h10);
      chk("flush_pre_level", level, 6);
      flush = 1'b1; m_ready = 1'b1;
      mem[6] = 8'h66; wr_en = 1'b1;
      @(negedge clk);
      flush = 1'b0; m_ready = 1'b0; wr_en = 1'b0;
      chk("flush_valid", m_valid, 0);
      chk("flush_rd_ptr", rd_ptr, 6);
      chk("flush_level", level, 0);
      chk("flush_empty", empty, 1);
      @(negedge clk);
      chk("flush_keep_valid", m_valid, 1);
      chk("flush_keep_data", m_data, 8'h66);
      chk("flush_keep_rd_ptr", rd_ptr, 7);
      chk("flush_keep_level", level, 1);

      // reset mid-stream with level 6
      do_reset();
      for (int i = 0; i < 6; i++) mem[i] = 8'(8'h20 + i);
      wr_jump = 1'b1; wr_jump_val = 4'd6;
      @(negedge clk);
      wr_jump = 1'b0;
      @(negedge clk);
      chk("midrst_pre_level", level, 6);
      chk("midrst_pre_data", m_data, 8'h20);
      reset = 1'b1; m_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0; m_ready = 1'b0;
      chk("midrst_valid", m_valid, 0);
      chk("midrst_data", m_data, 0);
      chk("midrst_level", level, 0);
      chk("midrst_empty", empty, 1);
      chk("midrst_rd_ptr", rd_ptr, 0);
      chk("midrst_rd_addr", rd_addr, 0);
      @(negedge clk);
      chk("midrst_after_valid", m_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
